// File: rtl/pixel_pkg.sv
// Shared pixel type, zero pixel and chunk-generator state encoding.
// Imported by the pixel stream interface and by every chunk_gen file.
package pixel_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
    } pixel_t;

    localparam pixel_t PIXEL_ZERO = '0;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } gen_state_t;

    // True when an image coordinate lies inside [0, lim).
    function automatic logic in_range(input int pos, input int lim);
        return (pos >= 0) && (pos < lim);
    endfunction

endpackage

// File: rtl/axis_if.sv
// Valid/ready stream carrying one item of type T per transfer.
// A transfer happens on a clock edge where ok (vld & rdy) is high.
interface axis_if #(
    parameter type T = pixel_pkg::pixel_t
);
    T     data;
    logic vld;
    logic rdy;
    logic ok;

    assign ok = vld & rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, input ok, output rdy);

endinterface

// File: rtl/line_buf.sv
// Fixed-length pixel delay line: dout is the pixel written DEPTH enabled
// shifts ago, built as a ring buffer that is read before it is overwritten.
module line_buf
    import pixel_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  pixel_t din,
    output pixel_t dout
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pixel_t           mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            // NOTE: clearing every entry on reset rules out mapping this array
            // to a RAM macro; it is kept so the post-reset state is fully defined.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PIXEL_ZERO;
            end
        end else if (en) begin
            // NOTE: non-blocking writes keep the read of mem[ptr] this cycle
            // returning the old entry, which is what makes the delay exactly DEPTH.
            mem[ptr] <= din;
            ptr      <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/chunk_gen.sv
// Turns a raster pixel stream into one zero-padded DIM x DIM neighbourhood
// per pixel, flushing the trailing chunks itself once a frame has been received.
module chunk_gen
    import pixel_pkg::*;
#(
    parameter int DIM    = 3,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic   clk,
    input  logic   rst,
    axis_if.slave  axis_i,
    axis_if.master axis_o
);
    localparam int H         = DIM / 2;
    localparam int FILL_LAST = H * WIDTH + H - 1;
    localparam int IN_LAST   = WIDTH * HEIGHT - 1;
    localparam int ADV_LAST  = WIDTH * HEIGHT + H * WIDTH + H - 1;
    localparam int ADV_W     = $clog2(ADV_LAST + 1);
    localparam int COL_W     = $clog2(WIDTH);
    localparam int ROW_W     = $clog2(HEIGHT);

    typedef pixel_t [DIM-1:0][DIM-1:0] chunk_t;

    gen_state_t       state;
    logic [ADV_W-1:0] adv_cnt;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    chunk_t           win;
    chunk_t           win_nxt;
    chunk_t           chunk_m;
    chunk_t           data_q;
    logic             vld_q;
    logic             slot_free;
    logic             adv;
    logic             emit;
    logic             last_chunk;
    pixel_t           shift_px;
    pixel_t           lb_in  [DIM-1];
    pixel_t           lb_out [DIM-1];
    pixel_t           row_in [DIM];

    assign slot_free  = !vld_q || axis_o.rdy;
    assign axis_i.rdy = slot_free && (state != FLUSH);
    assign adv        = slot_free && (axis_i.ok || state == FLUSH);
    assign emit       = (state != FILL);
    assign last_chunk = (out_row == ROW_W'(HEIGHT - 1)) && (out_col == COL_W'(WIDTH - 1));
    assign shift_px   = (state == FLUSH) ? PIXEL_ZERO : axis_i.data;

    assign axis_o.vld  = vld_q;
    assign axis_o.data = data_q;

    // Line buffer k delays the stream by (k+1) image rows.
    for (genvar k = 0; k < DIM - 1; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign lb_in[k] = shift_px;
        end else begin : g_chain
            assign lb_in[k] = lb_out[k-1];
        end

        line_buf #(
            .DEPTH(WIDTH)
        ) u_line_buf (
            .clk (clk),
            .rst (rst),
            .en  (adv),
            .din (lb_in[k]),
            .dout(lb_out[k])
        );
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the loops below can leave a value held, i.e. no latch.
        chunk_m = '0;
        win_nxt = '0;

        row_in[DIM-1] = shift_px;
        for (int k = 1; k < DIM; k++) begin
            row_in[DIM-1-k] = lb_out[k-1];
        end

        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
            win_nxt[r][DIM-1] = row_in[r];
        end

        // Taps outside the image, including row wrap from the line buffers, read as zero.
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                if (in_range(int'(out_row) + i - H, HEIGHT) &&
                    in_range(int'(out_col) + j - H, WIDTH)) begin
                    chunk_m[i][j] = win_nxt[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FILL;
            adv_cnt <= '0;
            out_row <= '0;
            out_col <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            win     <= '0;
        end else if (adv) begin
            win     <= win_nxt;
            vld_q   <= emit;
            adv_cnt <= adv_cnt + 1'b1;

            if (emit) begin
                data_q <= chunk_m;
                if (out_col == COL_W'(WIDTH - 1)) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_W'(HEIGHT - 1)) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end

            unique case (state)
                FILL: begin
                    if (adv_cnt == ADV_W'(FILL_LAST)) state <= RUN;
                end
                RUN: begin
                    if (adv_cnt == ADV_W'(IN_LAST)) state <= FLUSH;
                end
                FLUSH: begin
                    // Later assignments override the counter updates above.
                    if (last_chunk) begin
                        state   <= FILL;
                        adv_cnt <= '0;
                        out_row <= '0;
                        out_col <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end else if (slot_free) begin
            vld_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chunk_gen.sv
// Directed bench for chunk_gen on a 4x3 image with a 3x3 window: hand-computed
// tap table, neighbourhood model per chunk, backpressure, back-to-back and reset.
module tb_chunk_gen;
    import pixel_pkg::*;

    localparam int W    = 4;
    localparam int HT   = 3;
    localparam int NPIX = W * HT;
    localparam int NTAP = 34;

    typedef pixel_t [2:0][2:0] chunk_t;

    typedef struct {
        int         chunk;
        int         i;
        int         j;
        logic [7:0] red;
    } tap_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    axis_if #(.T(pixel_t)) in_if ();
    axis_if #(.T(chunk_t)) out_if ();

    chunk_gen #(
        .DIM   (3),
        .WIDTH (W),
        .HEIGHT(HT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .axis_i(in_if),
        .axis_o(out_if)
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_fail   = 0;
    chunk_t   got[$];
    chunk_t   basic[NPIX];
    tap_vec_t taps[NTAP];
    int       ncyc          = 0;
    int       acc_cnt       = 0;
    int       acc6_cyc      = -1;
    int       first_vld_cyc = -1;
    int       rdy_low       = 0;
    logic     prev_stall    = 1'b0;
    chunk_t   prev_data     = '0;
    bit       bp_en         = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observes handshakes on the falling edge, where every signal is settled.
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            if (in_if.vld && in_if.rdy) begin
                acc_cnt++;
                if (acc_cnt == 6) acc6_cyc = ncyc;
            end
            if (out_if.vld && first_vld_cyc < 0) first_vld_cyc = ncyc;
            if (!in_if.rdy) rdy_low++;
            if (prev_stall) check("stall_hold", {out_if.vld, out_if.data}, {1'b1, prev_data});
            prev_stall = out_if.vld && !out_if.rdy;
            prev_data  = out_if.data;
            if (out_if.vld && out_if.rdy) got.push_back(out_if.data);
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        out_if.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic chunk_t model(input int r, input int c, input int base);
        chunk_t m;
        m = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (r + i - 1 >= 0 && r + i - 1 < HT && c + j - 1 >= 0 && c + j - 1 < W)
                    m[i][j].red = 8'(base + (r + i - 1) * W + (c + j - 1));
            end
        end
        return m;
    endfunction

    task automatic clear_mon();
        got.delete();
        acc_cnt       = 0;
        acc6_cyc      = -1;
        first_vld_cyc = -1;
        rdy_low       = 0;
        prev_stall    = 1'b0;
    endtask

    // Presents one pixel and returns one cycle after the edge that takes it.
    task automatic send_px(input logic [7:0] red);
        pixel_t p;
        logic   acc;
        int     t;
        p          = PIXEL_ZERO;
        p.red      = red;
        in_if.data = p;
        in_if.vld  = 1'b1;
        t          = 0;
        do begin
            @(negedge clk);
            acc = in_if.rdy;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_accept: pixel %0d not taken within 200 cycles", red);
        end
    endtask

    task automatic send_frame(input int base);
        for (int k = 0; k < NPIX; k++) send_px(8'(base + k));
    endtask

    task automatic wait_chunks(input string name, input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 400) begin
            @(posedge clk);
            t++;
        end
        repeat (12) @(posedge clk);
        #1;
        check(name, got.size(), n);
    endtask

    task automatic check_frame(input string tag, input int first, input int base);
        chunk_t a;
        for (int k = 0; k < NPIX; k++) begin
            a = (first + k < got.size()) ? got[first + k] : '1;
            check($sformatf("%s_chunk%0d", tag, k), a, model(k / W, k % W, base));
        end
    endtask

    task automatic check_vs_basic(input string tag);
        chunk_t a;
        for (int k = 0; k < NPIX; k++) begin
            a = (k < got.size()) ? got[k] : '1;
            check($sformatf("%s_chunk%0d", tag, k), a, basic[k]);
        end
    endtask

    initial begin
        in_if.vld  = 1'b0;
        in_if.data = PIXEL_ZERO;

        // {chunk index, tap row, tap col, expected red}, basic frame red = pixel index.
        taps = '{
            '{0, 0, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 2, 0}, '{0, 1, 0, 0}, '{0, 1, 1, 0},
            '{0, 1, 2, 1}, '{0, 2, 0, 0}, '{0, 2, 1, 4}, '{0, 2, 2, 5},
            '{11, 0, 0, 6}, '{11, 0, 1, 7}, '{11, 0, 2, 0}, '{11, 1, 0, 10}, '{11, 1, 1, 11},
            '{11, 1, 2, 0}, '{11, 2, 0, 0}, '{11, 2, 1, 0}, '{11, 2, 2, 0},
            '{7, 0, 2, 0}, '{7, 1, 2, 0}, '{7, 2, 2, 0}, '{7, 0, 1, 3}, '{7, 1, 1, 7},
            '{7, 2, 1, 11}, '{7, 1, 0, 6},
            '{4, 0, 0, 0}, '{4, 1, 0, 0}, '{4, 2, 0, 0}, '{4, 1, 1, 4}, '{4, 2, 1, 8},
            '{4, 1, 2, 5},
            '{5, 0, 2, 2}, '{5, 2, 0, 8}, '{5, 2, 2, 10}
        };

        repeat (3) @(posedge clk);
        #1;
        check("reset_vld", out_if.vld, 1'b0);
        check("reset_data", out_if.data, 0);
        check("reset_in_rdy", in_if.rdy, 1'b1);
        rst = 1'b1;
        clear_mon();

        // Basic frame, no backpressure.
        send_frame(0);
        in_if.vld = 1'b0;
        wait_chunks("basic_count", NPIX);
        check("basic_first_vld", first_vld_cyc, acc6_cyc + 1);
        check("basic_flush_rdy_low", rdy_low, 5);
        check("basic_rdy_after_flush", in_if.rdy, 1'b1);
        check_frame("basic", 0, 0);
        for (int k = 0; k < NPIX; k++) basic[k] = (k < got.size()) ? got[k] : '1;
        for (int n = 0; n < NTAP; n++) begin
            check($sformatf("tap_c%0d_%0d_%0d", taps[n].chunk, taps[n].i, taps[n].j),
                  basic[taps[n].chunk][taps[n].i][taps[n].j].red, taps[n].red);
        end

        // Same frame under random output backpressure.
        clear_mon();
        bp_en = 1'b1;
        send_frame(0);
        in_if.vld = 1'b0;
        wait_chunks("bp_count", NPIX);
        bp_en = 1'b0;
        check_vs_basic("bp");

        // Two frames with vld held high across the boundary.
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        send_frame(0);
        send_frame(100);
        in_if.vld = 1'b0;
        wait_chunks("b2b_count", 2 * NPIX);
        check_frame("b2b_f0", 0, 0);
        check_frame("b2b_f1", NPIX, 100);

        // Reset after seven pixels, then a clean frame.
        clear_mon();
        for (int k = 0; k < 7; k++) send_px(8'(k));
        check("pre_reset_vld", out_if.vld, 1'b1);
        rst       = 1'b0;
        in_if.vld = 1'b0;
        #1;
        check("reset_vld_drop", out_if.vld, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_mon();
        send_frame(0);
        in_if.vld = 1'b0;
        wait_chunks("rst_count", NPIX);
        check("rst_first_vld", first_vld_cyc, acc6_cyc + 1);
        check_vs_basic("rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
